// File: rtl/dwt_subband_quant_if.sv
// Subband read port plus quantised-coefficient stream.
// master: quantiser side (drives reads and coef_*); slave: memory/coder side.
interface dwt_subband_quant_if #(
    parameter int DATA_W = 8
) ();
    logic              rd_en_o;
    logic [1:0]        rd_band_o;
    logic [2:0]        rd_row_o;
    logic [2:0]        rd_col_o;
    logic [DATA_W-1:0] rd_data_i;
    logic              coef_valid_o;
    logic              coef_ready_i;
    logic [DATA_W-1:0] coef_data_o;
    logic [1:0]        coef_band_o;
    logic              coef_last_o;

    modport master (
        output rd_en_o, rd_band_o, rd_row_o, rd_col_o,
        input  rd_data_i,
        output coef_valid_o, coef_data_o, coef_band_o, coef_last_o,
        input  coef_ready_i
    );

    modport slave (
        input  rd_en_o, rd_band_o, rd_row_o, rd_col_o,
        output rd_data_i,
        input  coef_valid_o, coef_data_o, coef_band_o, coef_last_o,
        output coef_ready_i
    );
endinterface

// File: rtl/dwt_subband_quant.sv
// Reads LL/LH/HL/HH subbands in band/row/col order, dead-zone quantises
// and streams them out. Ports: sys_clk, sys_rst (sync, high), start_i,
// bus (read port + coef stream), busy_o, frame_done_o, nz_count_o.
module dwt_subband_quant #(
    parameter int L_SIZE = 6,
    parameter int H_SIZE = 7,
    parameter int DATA_W = 8,
    parameter int THRESH = 4,
    parameter int SHIFT  = 1
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       start_i,
    dwt_subband_quant_if.master        bus,
    output logic                       busy_o,
    output logic                       frame_done_o,
    output logic [7:0]                 nz_count_o
);
    localparam int TOTAL = L_SIZE * L_SIZE + 2 * L_SIZE * H_SIZE
                         + H_SIZE * H_SIZE;
    localparam logic [7:0] LAST_IDX = 8'(TOTAL - 1);
    localparam int QMAX = 2 ** (DATA_W - 1) - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [1:0]        r_band;
    logic [2:0]        r_row;
    logic [2:0]        r_col;
    logic [7:0]        r_rd_cnt;
    logic [7:0]        r_out_cnt;
    logic              r_if_vld;
    logic [1:0]        r_if_band;
    logic              r_if_last;
    logic [DATA_W-1:0] r_fd [2];
    logic [1:0]        r_fb [2];
    logic              r_fl [2];
    logic              r_fnz [2];
    logic              r_wp;
    logic              r_rp;
    logic [1:0]        r_occ;
    logic              r_done;
    logic [7:0]        r_nz;

    logic              w_start;
    logic              w_valid;
    logic              w_pop;
    logic              w_rd_en;
    logic [2:0]        w_slots;
    logic [2:0]        w_col_max;
    logic [2:0]        w_row_max;
    logic              w_col_end;
    logic              w_row_end;

    logic              w_sign;
    logic [DATA_W:0]   w_ext;
    logic [DATA_W:0]   w_mag;
    logic [DATA_W:0]   w_shm;
    logic [DATA_W-1:0] w_qm;
    logic [DATA_W-1:0] w_q;

    assign w_start = (r_state == S_IDLE) && start_i;
    assign w_valid = (r_occ != 2'd0);
    assign w_pop   = w_valid && bus.coef_ready_i;

    // Entries held or about to land, with this cycle's pop already freed.
    assign w_slots = {1'b0, r_occ} + {2'b0, r_if_vld} - {2'b0, w_pop};

    // Bands 2/3 are H wide, bands 1/3 are H tall.
    assign w_col_max = r_band[1] ? 3'(H_SIZE - 1) : 3'(L_SIZE - 1);
    assign w_row_max = r_band[0] ? 3'(H_SIZE - 1) : 3'(L_SIZE - 1);
    assign w_col_end = (r_col == w_col_max);
    assign w_row_end = (r_row == w_row_max);

    // Magnitude is one bit wider so that the most negative code maps cleanly.
    always_comb begin
        w_sign = bus.rd_data_i[DATA_W-1];
        w_ext  = {w_sign, bus.rd_data_i};
        w_mag  = w_sign ? (~w_ext + (DATA_W+1)'(1)) : w_ext;
        w_shm  = w_mag >> SHIFT;
        w_qm   = (w_shm > (DATA_W+1)'(QMAX)) ? DATA_W'(QMAX)
                                             : w_shm[DATA_W-1:0];
        w_q    = '0;
        if (r_if_band == 2'd0)
            w_q = bus.rd_data_i >> SHIFT;
        else if (w_mag < (DATA_W+1)'(THRESH))
            w_q = '0;
        else
            w_q = w_sign ? (~w_qm + DATA_W'(1)) : w_qm;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start_i)
                    w_next = S_RUN;
            end
            S_RUN: begin
                if (w_slots < 3'd2) begin
                    w_rd_en = 1'b1;
                    if (r_rd_cnt == LAST_IDX)
                        w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && (r_out_cnt == LAST_IDX))
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_band    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_rd_cnt  <= '0;
            r_out_cnt <= '0;
            r_if_vld  <= 1'b0;
            r_if_band <= '0;
            r_if_last <= 1'b0;
            r_wp      <= 1'b0;
            r_rp      <= 1'b0;
            r_occ     <= '0;
            r_done    <= 1'b0;
            r_nz      <= '0;
            for (int i = 0; i < 2; i++) begin
                r_fd[i]  <= '0;
                r_fb[i]  <= '0;
                r_fl[i]  <= 1'b0;
                r_fnz[i] <= 1'b0;
            end
        end else begin
            r_done   <= (r_state == S_DRAIN) && (w_next == S_IDLE);
            r_if_vld <= w_rd_en;
            r_occ    <= r_occ + 2'(r_if_vld) - 2'(w_pop);

            if (w_start) begin
                r_band    <= '0;
                r_row     <= '0;
                r_col     <= '0;
                r_rd_cnt  <= '0;
                r_out_cnt <= '0;
                r_nz      <= '0;
            end

            if (w_rd_en) begin
                r_if_band <= r_band;
                r_if_last <= w_col_end && w_row_end;
                r_rd_cnt  <= r_rd_cnt + 8'd1;
                if (w_col_end) begin
                    r_col <= '0;
                    if (w_row_end) begin
                        r_row  <= '0;
                        r_band <= r_band + 2'd1;
                    end else begin
                        r_row <= r_row + 3'd1;
                    end
                end else begin
                    r_col <= r_col + 3'd1;
                end
            end

            if (r_if_vld) begin
                r_fd[r_wp]  <= w_q;
                r_fb[r_wp]  <= r_if_band;
                r_fl[r_wp]  <= r_if_last;
                r_fnz[r_wp] <= (w_q != '0);
                r_wp        <= ~r_wp;
            end

            if (w_pop) begin
                r_rp      <= ~r_rp;
                r_out_cnt <= r_out_cnt + 8'd1;
                if (r_fnz[r_rp])
                    r_nz <= r_nz + 8'd1;
            end
        end
    end

    assign bus.rd_en_o      = w_rd_en;
    assign bus.rd_band_o    = r_band;
    assign bus.rd_row_o     = r_row;
    assign bus.rd_col_o     = r_col;
    assign bus.coef_valid_o = w_valid;
    assign bus.coef_data_o  = r_fd[r_rp];
    assign bus.coef_band_o  = r_fb[r_rp];
    assign bus.coef_last_o  = r_fl[r_rp];
    assign busy_o           = (r_state != S_IDLE);
    assign frame_done_o     = r_done;
    assign nz_count_o       = r_nz;
endmodule
